alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter SKID, default 1: 1 = two-entry skid buffer with registered inst_ready; 0 = one-entry register with inst_ready = !alu_valid || alu_ready.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discard all buffered entries and any same-cycle input.
REQ-005 inst_valid  input  1  inst/pc/rs1_data/rs2_data valid.
REQ-006 inst_ready  output  1  block accepts the current input.
REQ-007 inst  input  32  RV32I instruction word.
REQ-008 pc  input  data_t  instruction address.
REQ-009 rs1_data, rs2_data  input  data_t  register-file read data.
REQ-010 alu_valid  output  1  ALU request valid.
REQ-011 alu_ready  input  1  ALU stage accepts the request.
REQ-012 alu_opcode  output  alu_t  ALU operation.
REQ-013 alu_op1, alu_op2  output  data_t  ALU operands.
REQ-014 rd  output  5  destination register, inst[11:7].
REQ-015 rd_we  output  1  writeback enable.
REQ-016 illegal  output  1  instruction not decodable by this block.

Function
REQ-017 Input transfer SHALL occur on inst_valid && inst_ready; output transfer SHALL occur on alu_valid && alu_ready.
REQ-018 Latency SHALL be 1 cycle: an instruction accepted into an empty block appears on alu_* the next cycle.
REQ-019 While alu_valid && !alu_ready, all alu_* outputs SHALL hold stable.
REQ-020 Ordering SHALL be strict FIFO; no loss, no duplication; full throughput (1 per cycle) when alu_ready stays high.
REQ-021 OP (0110011): op1 = rs1_data, op2 = rs2_data; funct3 000/001/010/011/100/101/110/111 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; funct7 0100000 legal only with 000 (SUB) and 101 (SRA); any other funct7 != 0000000 -> illegal.
REQ-022 OP-IMM (0010011): op1 = rs1_data, op2 = sign-extended inst[31:20]; same funct3 map, no SUB; SLLI/SRLI/SRAI: op2 = zero-extended inst[24:20], inst[31:25] must be 0000000 (0100000 for SRAI), otherwise illegal.
REQ-023 LUI (0110111): ALU_OP2, op2 = {inst[31:12], 12'b0}, op1 = 0.
REQ-024 AUIPC (0010111): ALU_ADD, op1 = pc, op2 = {inst[31:12], 12'b0}.
REQ-025 Any other opcode, or inst[1:0] != 11: illegal = 1, alu_opcode = ALU_XXX, rd_we = 0; the entry still transfers normally.
REQ-026 rd_we SHALL be 1 only for legal instructions with rd != 0.
REQ-027 SKID=1: inst_ready SHALL be a flop output, low exactly when both entries are occupied; an input accepted while the output entry stalls goes to the skid entry and moves to the output entry on the next output transfer.
REQ-028 Simultaneous input and output transfer SHALL leave occupancy unchanged.
REQ-029 flush SHALL take priority: the next cycle alu_valid = 0, occupancy = 0, inst_ready = 1; input offered in the flush cycle is dropped.

Reset
REQ-030 While reset is high: alu_valid = 0, inst_ready = 1 (SKID=1) and inputs ignored; after reset occupancy = 0.
REQ-031 Datapath registers (alu_opcode, operands, rd, rd_we, illegal) SHALL NOT require reset; rd_we and illegal are qualified by alu_valid.
REQ-032 Reset asserted mid-stall SHALL discard all entries, identical to flush.

Structure
REQ-033 The riscv package SHALL hold the opcode constants (OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC), the funct3/funct7 constants, and a packed struct alu_req_t (opcode, op1, op2, rd, rd_we, illegal); alu_t and data_t stay there.
REQ-034 The decode SHALL be combinational ahead of the buffer; buffering SHALL be one sub-module skid_buffer, parameterized on payload type, clocked by clk/reset with flush.

Verification
REQ-035 inst 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> next cycle alu_valid, ALU_ADD, op1=5, op2=7, rd=3, rd_we=1.
REQ-036 inst 0x40335293 (srai x5,x6,3), rs1=0x80000000 -> ALU_SRA, op1=0x80000000, op2=3; inst 0xFFF00093 (addi x1,x0,-1) -> ALU_ADD, op2=0xFFFFFFFF.
REQ-037 inst 0x12345217 (auipc x4), pc=0x100 -> ALU_ADD, op1=0x100, op2=0x12345000, rd=4.
REQ-038 inst 0x00000000 -> illegal=1, ALU_XXX, rd_we=0; inst 0x7E0081B3 (funct7 0111111) -> illegal=1.
REQ-039 alu_ready=0, three back-to-back valid inputs A,B,C -> A,B accepted, inst_ready low on C, outputs hold A; alu_ready=1 -> A,B,C delivered in order, one per cycle.
REQ-040 Two entries buffered, flush pulse -> next cycle alu_valid=0, inst_ready=1; first subsequent instruction appears after 1 cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I integer-ALU definitions shared by the issue decode and its buffer.
package riscv_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_OP2, ALU_XXX
  } alu_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_t       opcode;
    data_t      op1;
    data_t      op2;
    logic [4:0] rd;
    logic       rd_we;
    logic       illegal;
  } alu_req_t;

  // Base operation for a funct3 value; SUB/SRA are selected by funct7.
  function automatic alu_t funct3_to_alu(input logic [2:0] f3);
    alu_t op;
    case (f3)
      F3_ADD:  op = ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SRL:  op = ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Valid/ready pipeline buffer: two-entry skid with registered ready, or a single register.
module skid_buffer #(
  parameter type T    = logic [7:0],
  parameter int  SKID = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  generate
    if (SKID != 0) begin : g_skid
      logic r_out_valid;
      logic r_skid_valid;
      logic r_ready;
      T     r_out_data;
      T     r_skid_data;
      logic w_in_fire;
      logic w_load_out;
      logic w_out_valid_next;
      logic w_skid_valid_next;

      assign w_in_fire  = i_valid && r_ready;
      assign w_load_out = !r_out_valid || i_ready;

      // The skid entry only fills while the output entry is stalled, so
      // r_ready being high guarantees it is empty when w_in_fire is set.
      always_comb begin
        w_out_valid_next  = r_out_valid;
        w_skid_valid_next = r_skid_valid;
        if (w_load_out) begin
          w_out_valid_next  = r_skid_valid || w_in_fire;
          w_skid_valid_next = 1'b0;
        end else if (w_in_fire) begin
          w_skid_valid_next = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
          r_ready      <= 1'b1;
        end else begin
          r_out_valid  <= w_out_valid_next;
          r_skid_valid <= w_skid_valid_next;
          r_ready      <= !w_skid_valid_next;
        end
      end

      always_ff @(posedge clk) begin
        if (w_load_out) begin
          r_out_data <= r_skid_valid ? r_skid_data : i_data;
        end
        if (w_in_fire && !w_load_out) begin
          r_skid_data <= i_data;
        end
      end

      assign o_ready = r_ready;
      assign o_valid = r_out_valid;
      assign o_data  = r_out_data;
    end else begin : g_reg
      logic r_valid;
      T     r_data;
      logic w_ready;

      assign w_ready = !r_valid || i_ready;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          r_valid <= 1'b0;
        end else if (w_ready) begin
          r_valid <= i_valid;
        end
      end

      always_ff @(posedge clk) begin
        if (w_ready && i_valid) begin
          r_data <= i_data;
        end
      end

      assign o_ready = w_ready;
      assign o_valid = r_valid;
      assign o_data  = r_data;
    end
  endgenerate

endmodule

// File: rtl/alu_issue.sv
// RV32I integer-ALU issue stage: combinational decode feeding a valid/ready buffer.
module alu_issue
  import riscv_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  data_t       pc,
  input  data_t       rs1_data,
  input  data_t       rs2_data,
  output logic        alu_valid,
  input  logic        alu_ready,
  output alu_t        alu_opcode,
  output data_t       alu_op1,
  output data_t       alu_op2,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  data_t      w_imm_u;
  alu_req_t   w_req;
  alu_req_t   w_out;
  logic       w_unused_rs1_idx;

  assign w_opc   = inst[6:0];
  assign w_f3    = inst[14:12];
  assign w_f7    = inst[31:25];
  assign w_imm_u = {inst[31:12], 12'b0};

  // Source register indices are resolved upstream; only their data arrives here.
  assign w_unused_rs1_idx = ^inst[19:15];

  always_comb begin
    w_req.opcode  = ALU_XXX;
    w_req.op1     = rs1_data;
    w_req.op2     = rs2_data;
    w_req.rd      = inst[11:7];
    w_req.rd_we   = 1'b0;
    w_req.illegal = 1'b1;
    case (w_opc)
      OPCODE_OP: begin
        w_req.opcode  = funct3_to_alu(w_f3);
        w_req.illegal = 1'b0;
        if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
          w_req.opcode = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == F3_SRL) begin
          w_req.opcode = ALU_SRA;
        end else if (w_f7 != F7_BASE) begin
          w_req.illegal = 1'b1;
        end
      end
      OPCODE_OP_IMM: begin
        w_req.opcode  = funct3_to_alu(w_f3);
        w_req.op2     = {{20{inst[31]}}, inst[31:20]};
        w_req.illegal = 1'b0;
        // Shift immediates carry a shamt plus a funct7 qualifier instead of imm[11:5].
        if (w_f3 == F3_SLL || w_f3 == F3_SRL) begin
          w_req.op2 = {27'b0, inst[24:20]};
          if (w_f3 == F3_SRL && w_f7 == F7_ALT) begin
            w_req.opcode = ALU_SRA;
          end else if (w_f7 != F7_BASE) begin
            w_req.illegal = 1'b1;
          end
        end
      end
      OPCODE_LUI: begin
        w_req.opcode  = ALU_OP2;
        w_req.op1     = '0;
        w_req.op2     = w_imm_u;
        w_req.illegal = 1'b0;
      end
      OPCODE_AUIPC: begin
        w_req.opcode  = ALU_ADD;
        w_req.op1     = pc;
        w_req.op2     = w_imm_u;
        w_req.illegal = 1'b0;
      end
      default: ;
    endcase
    if (w_req.illegal) begin
      w_req.opcode = ALU_XXX;
    end
    w_req.rd_we = !w_req.illegal && (w_req.rd != 5'd0);
  end

  skid_buffer #(
    .T    (alu_req_t),
    .SKID (SKID)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .i_valid (inst_valid),
    .o_ready (inst_ready),
    .i_data  (w_req),
    .o_valid (alu_valid),
    .i_ready (alu_ready),
    .o_data  (w_out)
  );

  assign alu_opcode = w_out.opcode;
  assign alu_op1    = w_out.op1;
  assign alu_op2    = w_out.op2;
  assign rd         = w_out.rd;
  assign rd_we      = alu_valid && w_out.rd_we;
  assign illegal    = alu_valid && w_out.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed checks of alu_issue decode, skid buffering, flush and reset.
module tb_alu_issue;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, inst_valid, inst_ready;
  logic [31:0] inst;
  data_t       pc, rs1_data, rs2_data, alu_op1, alu_op2;
  logic        alu_valid, alu_ready, rd_we, illegal;
  alu_t        alu_opcode;
  logic [4:0]  rd;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue #(.SKID(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .rd         (rd),
    .rd_we      (rd_we),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer an instruction at the current negedge, then check the decoded result one cycle later.
  task automatic run_vec(input string tag, input logic [31:0] i_inst, input data_t i_pc,
                         input data_t i_rs1, input data_t i_rs2, input alu_t e_op,
                         input data_t e_op1, input data_t e_op2, input logic [4:0] e_rd,
                         input logic e_we, input logic e_ill);
    inst = i_inst; pc = i_pc; rs1_data = i_rs1; rs2_data = i_rs2;
    inst_valid = 1'b1; alu_ready = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    check({tag, ".valid"}, 32'(alu_valid), 32'd1);
    check({tag, ".op"},    32'(alu_opcode), 32'(e_op));
    if (!e_ill) begin
      check({tag, ".op1"}, alu_op1, e_op1);
      check({tag, ".op2"}, alu_op2, e_op2);
    end
    check({tag, ".rd"},    32'(rd), 32'(e_rd));
    check({tag, ".rd_we"}, 32'(rd_we), 32'(e_we));
    check({tag, ".ill"},   32'(illegal), 32'(e_ill));
    $display("vec %s inst=%08h op=%0d op1=%08h op2=%08h rd=%0d we=%0b ill=%0b",
             tag, i_inst, alu_opcode, alu_op1, alu_op2, rd, rd_we, illegal);
  endtask

  // Present "add xN,x1,x2" with a tagging rs1 value; does not wait.
  task automatic drive(input logic [4:0] rdn, input data_t r1);
    inst = 32'h0020_8033 | (32'(rdn) << 7);
    pc = '0; rs1_data = r1; rs2_data = '0;
    inst_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; alu_ready = 1'b1;
    inst = 32'h0020_81B3; pc = '0; rs1_data = 32'd1; rs2_data = 32'd2;
    inst_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(alu_valid), 32'd0);
    check("rst.ready", 32'(inst_ready), 32'd1);
    reset = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    check("post_rst.valid", 32'(alu_valid), 32'd0);
    $display("reset done");

    run_vec("add",   32'h0020_81B3, 32'h0, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    run_vec("srai",  32'h4033_5293, 32'h0, 32'h8000_0000, 32'd9, ALU_SRA, 32'h8000_0000, 32'd3, 5'd5, 1'b1, 1'b0);
    run_vec("addi",  32'hFFF0_0093, 32'h0, 32'd0, 32'd9, ALU_ADD, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
    run_vec("auipc", 32'h1234_5217, 32'h100, 32'd9, 32'd9, ALU_ADD, 32'h100, 32'h1234_5000, 5'd4, 1'b1, 1'b0);
    run_vec("zero",  32'h0000_0000, 32'h0, 32'd1, 32'd2, ALU_XXX, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    run_vec("f7bad", 32'h7E00_81B3, 32'h0, 32'd1, 32'd2, ALU_XXX, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
    run_vec("lui",   32'h1234_50B7, 32'h0, 32'd7, 32'd7, ALU_OP2, 32'd0, 32'h1234_5000, 5'd1, 1'b1, 1'b0);
    run_vec("sub",   32'h4020_81B3, 32'h0, 32'd10, 32'd3, ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0);
    run_vec("add_x0", 32'h0020_8033, 32'h0, 32'd1, 32'd2, ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);
    run_vec("slli",  32'h0050_9093, 32'h0, 32'd6, 32'd9, ALU_SLL, 32'd6, 32'd5, 5'd1, 1'b1, 1'b0);
    run_vec("slli_bad", 32'h4050_9093, 32'h0, 32'd6, 32'd9, ALU_XXX, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1);
    @(negedge clk);
    check("drain.valid", 32'(alu_valid), 32'd0);

    // Stall: A and B accepted, C refused until the output moves.
    alu_ready = 1'b0;
    drive(5'd1, 32'd11);
    check("stall.rdyA", 32'(inst_ready), 32'd1);
    @(negedge clk);
    check("stall.outA", 32'(rd), 32'd1);
    drive(5'd2, 32'd22);
    check("stall.rdyB", 32'(inst_ready), 32'd1);
    @(negedge clk);
    check("stall.full", 32'(inst_ready), 32'd0);
    check("stall.holdA", 32'(rd), 32'd1);
    drive(5'd3, 32'd33);
    @(negedge clk);
    check("stall.blockC", 32'(inst_ready), 32'd0);
    check("stall.holdA2", alu_op1, 32'd11);
    check("stall.valid", 32'(alu_valid), 32'd1);
    alu_ready = 1'b1;
    @(negedge clk);
    check("stall.outB", 32'(rd), 32'd2);
    check("stall.outB_op1", alu_op1, 32'd22);
    check("stall.rdy_again", 32'(inst_ready), 32'd1);
    @(negedge clk);
    inst_valid = 1'b0;
    check("stall.outC", 32'(rd), 32'd3);
    check("stall.outC_valid", 32'(alu_valid), 32'd1);
    @(negedge clk);
    check("stall.empty", 32'(alu_valid), 32'd0);
    $display("stall sequence done");

    // Flush with two entries buffered and an input offered in the flush cycle.
    alu_ready = 1'b0;
    drive(5'd4, 32'd44);
    @(negedge clk);
    drive(5'd5, 32'd55);
    @(negedge clk);
    check("flush.pre_full", 32'(inst_ready), 32'd0);
    flush = 1'b1;
    drive(5'd6, 32'd66);
    @(negedge clk);
    flush = 1'b0; inst_valid = 1'b0;
    check("flush.valid", 32'(alu_valid), 32'd0);
    check("flush.ready", 32'(inst_ready), 32'd1);
    alu_ready = 1'b1;
    drive(5'd7, 32'd77);
    @(negedge clk);
    inst_valid = 1'b0;
    check("flush.next_valid", 32'(alu_valid), 32'd1);
    check("flush.next_rd", 32'(rd), 32'd7);
    @(negedge clk);
    check("flush.no_dup", 32'(alu_valid), 32'd0);

    // Flush with room available: the offered input is still dropped.
    flush = 1'b1;
    drive(5'd8, 32'd88);
    @(negedge clk);
    flush = 1'b0; inst_valid = 1'b0;
    check("flush.drop_in", 32'(alu_valid), 32'd0);
    $display("flush sequence done");

    // Reset while stalled with two entries.
    alu_ready = 1'b0;
    drive(5'd9, 32'd99);
    @(negedge clk);
    drive(5'd10, 32'd100);
    @(negedge clk);
    reset = 1'b1; inst_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst.valid", 32'(alu_valid), 32'd0);
    check("midrst.ready", 32'(inst_ready), 32'd1);
    $display("mid-stall reset done");

    // Back-to-back stream at full throughput.
    alu_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(5'(11 + k), 32'(200 + k));
      @(negedge clk);
      check("stream.valid", 32'(alu_valid), 32'd1);
      check("stream.rd", 32'(rd), 32'(11 + k));
      check("stream.ready", 32'(inst_ready), 32'd1);
      $display("stream beat %0d rd=%0d op1=%0d", k, rd, alu_op1);
    end
    inst_valid = 1'b0;
    @(negedge clk);
    check("stream.end", 32'(alu_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
